// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// The last winner may hold the memory for up to MAX_BURST consecutive grants; responses come back one cycle after the grant.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
  } req_t;

  req_t [1:0]              w_rq;
  req_t                    w_sel;
  logic [1:0]              w_req, w_gnt, w_rvalid;
  logic [1:0][DATA_W-1:0]  w_rdata;
  logic                    w_any, w_win;

  logic                    r_last, r_rsp_v, r_rsp_port, r_rsp_we;
  logic [BW-1:0]           r_burst;

  assign w_req   = {m1_req, m0_req};
  assign w_rq[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
  assign w_rq[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};

  // burst==0 means no streak is running yet, so the non-last port (port 0 after reset) wins contention.
  always_comb begin
    w_win = 1'b0;
    case (w_req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = (r_burst != '0 && r_burst < BURST_MAX) ? r_last : ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  assign w_any = reset && (|w_req);
  assign w_sel = w_rq[w_win];

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      assign w_gnt[p]    = w_any && (w_win == 1'(p));
      assign w_rvalid[p] = r_rsp_v && (r_rsp_port == 1'(p));
      assign w_rdata[p]  = (w_rvalid[p] && !r_rsp_we) ? mem_rdata : '0;
    end
  endgenerate

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = w_rvalid[0];
  assign m1_rvalid = w_rvalid[1];
  assign m0_rdata  = w_rdata[0];
  assign m1_rdata  = w_rdata[1];

  assign mem_en    = w_any;
  assign mem_we    = w_any && w_sel.we;
  assign mem_addr  = w_any ? w_sel.addr  : '0;
  assign mem_wdata = w_any ? w_sel.wdata : '0;
  assign mem_be    = w_any ? w_sel.be    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= 1'b1;
      r_burst    <= '0;
      r_rsp_v    <= 1'b0;
      r_rsp_port <= 1'b0;
      r_rsp_we   <= 1'b0;
    end else begin
      r_rsp_v <= w_any;
      if (w_any) begin
        r_last     <= w_win;
        r_rsp_port <= w_win;
        r_rsp_we   <= w_sel.we;
        if (w_win != r_last)
          r_burst <= BW'(1);
        else if (r_burst != BURST_MAX)
          r_burst <= r_burst + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a grant-history reference model.
// A small behavioural memory sits on the mem_* port.
module tb_dmem_arbiter;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: byte-masked writes, registered reads.
  logic [31:0] emem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) emem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= emem[mem_addr[9:2]];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of winners since reset, expected memory, one pending response.
  int          hist[$];
  logic [31:0] ref_mem [0:255];
  logic        pv;
  int          pport;
  logic [31:0] pdata;

  logic [1:0]  o_gnt, o_rv, e_gnt, e_rv;
  logic [31:0] o_rd0, o_rd1, e_rd0, e_rd1;
  logic        o_men;

  // Length of the current winning streak decides hold vs. yield.
  function automatic int model_winner(input logic q0, input logic q1);
    int run;
    if (!q0 && !q1) return -1;
    if (q0 && !q1) return 0;
    if (!q0 && q1) return 1;
    if (hist.size() == 0) return 0;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      run++;
    end
    return (run >= MAX_BURST) ? 1 - hist[hist.size()-1] : hist[hist.size()-1];
  endfunction

  task automatic model_clear();
    hist.delete();
    pv = 1'b0;
    pport = 0;
    pdata = '0;
  endtask

  // Samples outputs 1ns after the inputs settle, predicts, then commits the model at the clock edge.
  task automatic tick();
    int w;
    logic we;
    logic [31:0] a, d;
    logic [3:0] b;
    #1;
    o_gnt = {m1_gnt, m0_gnt};
    o_rv  = {m1_rvalid, m0_rvalid};
    o_rd0 = m0_rdata;
    o_rd1 = m1_rdata;
    o_men = mem_en;
    w = reset ? model_winner(m0_req, m1_req) : -1;
    e_gnt = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    e_rv  = 2'b00;
    e_rd0 = '0;
    e_rd1 = '0;
    if (pv) begin
      if (pport == 0) begin e_rv = 2'b01; e_rd0 = pdata; end
      else            begin e_rv = 2'b10; e_rd1 = pdata; end
    end
    @(posedge clk);
    pv = (w >= 0);
    if (w >= 0) begin
      hist.push_back(w);
      pport = w;
      if (w == 0) begin we = m0_we; a = m0_addr; d = m0_wdata; b = m0_be; end
      else        begin we = m1_we; a = m1_addr; d = m1_wdata; b = m1_be; end
      pdata = we ? 32'h0 : ref_mem[a[9:2]];
      if (we)
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[a[9:2]][8*k +: 8] = d[8*k +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({m1_gnt, m0_gnt, mem_en} !== 3'b000) begin
        n_fail++; $display("FAIL reset_gnt: got gnt=%b%b mem_en=%b, want 000", m1_gnt, m0_gnt, mem_en);
      end
      n_checks++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00 || m0_rdata !== 0 || m1_rdata !== 0) begin
        n_fail++; $display("FAIL reset_rsp: got rvalid=%b%b rdata0=%h rdata1=%h, want 0", m1_rvalid, m0_rvalid, m0_rdata, m1_rdata);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if (o_gnt !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_gnt: got %b, want 01", o_gnt);
    end
    idle_inputs();
  endtask

  task automatic test_single_port();
    apply_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'h0000000C; m1_be = 4'hF;
    tick();
    n_checks++;
    if (o_gnt !== 2'b10 || o_men !== 1'b1) begin
      n_fail++; $display("FAIL single_wr_gnt: got gnt=%b mem_en=%b, want 10/1", o_gnt, o_men);
    end
    m1_we = 0;
    tick();
    n_checks++;
    if (o_gnt !== 2'b10 || o_rv !== 2'b10 || o_rd1 !== 0) begin
      n_fail++; $display("FAIL single_wr_rsp: got gnt=%b rvalid=%b rdata1=%h, want 10/10/0", o_gnt, o_rv, o_rd1);
    end
    m1_req = 0;
    tick();
    n_checks++;
    if (o_rv !== 2'b10 || o_rd1 !== 32'h0000000C || o_rd0 !== 0 || o_gnt !== 2'b00) begin
      n_fail++; $display("FAIL single_rd_rsp: got rvalid=%b rdata1=%h rdata0=%h gnt=%b, want 10/0000000c/0/00", o_rv, o_rd1, o_rd0, o_gnt);
    end
  endtask

  task automatic test_burst_limit();
    int pat[12];
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    apply_reset();
    m0_addr = 32'h8; m1_addr = 32'h8;
    for (int k = 0; k <= 12; k++) begin
      m0_req = (k < 12); m1_req = (k < 12);
      tick();
      if (k < 12) begin
        n_checks++;
        if (o_gnt !== ((pat[k] == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL burst_gnt[%0d]: got %b, want port %0d", k, o_gnt, pat[k]);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (o_rv !== ((pat[k-1] == 1) ? 2'b10 : 2'b01) || (o_rd0 | o_rd1) !== 32'h0000000C) begin
          n_fail++; $display("FAIL burst_rsp[%0d]: got rvalid=%b rdata=%h/%h, want port %0d data 0000000c", k, o_rv, o_rd0, o_rd1, pat[k-1]);
        end
      end
    end
  endtask

  task automatic test_hold_yield();
    int first_g, second_g;
    first_g = -1; second_g = -1;
    apply_reset();
    m0_addr = 32'h8; m1_addr = 32'h8;
    for (int k = 0; k < 12; k++) begin
      m0_req = 1;
      m1_req = (k >= 2 && first_g < 0) || (k >= 7 && second_g < 0);
      tick();
      n_checks++;
      if (o_gnt !== e_gnt) begin
        n_fail++; $display("FAIL hold_gnt[%0d]: got %b, want %b", k, o_gnt, e_gnt);
      end
      if (o_gnt[1]) begin
        if (first_g < 0) first_g = k;
        else if (second_g < 0) second_g = k;
      end
    end
    n_checks++;
    if (first_g != 4) begin
      n_fail++; $display("FAIL hold_first_m1: got cycle %0d, want 4", first_g);
    end
    n_checks++;
    if (second_g != 9) begin
      n_fail++; $display("FAIL hold_burst_restart: got cycle %0d, want 9", second_g);
    end
    idle_inputs();
  endtask

  task automatic test_byte_enables();
    apply_reset();
    m0_req = 1; m0_we = 1; m0_addr = 0; m0_wdata = 32'hAABBCCDD; m0_be = 4'hF;
    tick();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 0; m1_wdata = 32'h11223344; m1_be = 4'h3;
    tick();
    m1_req = 0;
    m0_req = 1; m0_we = 0;
    tick();
    n_checks++;
    if (o_gnt !== 2'b01 || o_rv !== 2'b10) begin
      n_fail++; $display("FAIL be_rd_gnt: got gnt=%b rvalid=%b, want 01/10", o_gnt, o_rv);
    end
    m0_req = 0;
    tick();
    n_checks++;
    if (o_rv !== 2'b01 || o_rd0 !== 32'hAABB3344) begin
      n_fail++; $display("FAIL be_merge: got rvalid=%b rdata0=%h, want 01/aabb3344", o_rv, o_rd0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m0_req = 1; m0_we = 0; m0_addr = 0;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_gnt: got %b, want 1", m0_gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    m0_req = 0;
    @(negedge clk); #1;
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 0) begin
      n_fail++; $display("FAIL mid_drop: got rvalid=%b rdata=%h, want 0/0", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if (o_rv !== 2'b00) begin
      n_fail++; $display("FAIL mid_no_rsp: got rvalid=%b, want 00", o_rv);
    end
    m0_req = 1; m1_req = 1; m0_addr = 0; m1_addr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (o_gnt !== e_gnt || o_gnt !== ((k < 4) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL mid_restart[%0d]: got %b, model %b", k, o_gnt, e_gnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic act0, act1;
    apply_reset();
    for (int w = 0; w < 8; w++) begin
      m0_req = 1; m0_we = 1; m0_addr = 32'(w) << 2; m0_wdata = $urandom; m0_be = 4'hF;
      tick();
    end
    idle_inputs();
    act0 = 0; act1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!act0 && $urandom_range(0, 9) < 6) begin
        act0 = 1; m0_req = 1; m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 32'($urandom_range(0, 7)) << 2; m0_wdata = $urandom; m0_be = 4'($urandom_range(0, 15));
      end
      if (!act1 && $urandom_range(0, 9) < 6) begin
        act1 = 1; m1_req = 1; m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 32'($urandom_range(0, 7)) << 2; m1_wdata = $urandom; m1_be = 4'($urandom_range(0, 15));
      end
      tick();
      n_checks++;
      if (o_gnt !== e_gnt || o_men !== (|e_gnt)) begin
        n_fail++; $display("FAIL rand_gnt[%0d]: got gnt=%b mem_en=%b, want %b", k, o_gnt, o_men, e_gnt);
      end
      n_checks++;
      if (o_rv !== e_rv || o_rd0 !== e_rd0 || o_rd1 !== e_rd1) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: got rv=%b rd0=%h rd1=%h, want rv=%b rd0=%h rd1=%h", k, o_rv, o_rd0, o_rd1, e_rv, e_rd0, e_rd1);
      end
      if (e_gnt[0]) begin act0 = 0; m0_req = 0; end
      if (e_gnt[1]) begin act1 = 0; m1_req = 0; end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (o_rv !== e_rv || o_rd0 !== e_rd0 || o_rd1 !== e_rd1) begin
      n_fail++; $display("FAIL rand_flush: got rv=%b rd0=%h rd1=%h, want rv=%b rd0=%h rd1=%h", o_rv, o_rd0, o_rd1, e_rv, e_rd0, e_rd1);
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_burst_limit();
    test_hold_yield();
    test_byte_enables();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU datapath's load/store port (port 0) and a loader/debug port (port 1) used to preload or inspect memory. It sits between the requesters and the data memory. It uses round-robin arbitration with a bounded burst hold, drives the memory's single access port, and returns read data/acknowledge to the winning requester one cycle later.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (fixed to 32; byte enables are 4 bits)
- MAX_BURST, 4, max consecutive grants to one port while the other requests (≥1)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- m0_req, m1_req  input  1  access request
- m0_we, m1_we  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_W  byte address, word-aligned
- m0_wdata, m1_wdata  input  DATA_W  write data
- m0_be, m1_be  input  4  byte enables for writes
- m0_gnt, m1_gnt  output  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  output  1  response for access accepted last cycle
- m0_rdata, m1_rdata  output  DATA_W  read data, valid with rvalid
- mem_en  output  1  memory access this cycle
- mem_we  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_be  output  4  memory byte enables
- mem_rdata  input  DATA_W  registered read data, valid the cycle after a read with mem_en=1

## Operation
- Transfer happens when mN_req && mN_gnt. At most one gnt per cycle. gnt never asserts without req.
- Requester holds req/we/addr/wdata/be stable until gnt.
- State: last (last winner, 1 bit), burst (consecutive-grant count, 0..MAX_BURST), rsp_v/rsp_port/rsp_we (response pipeline register).
- Arbitration for each cycle, evaluated in order:
  - No requests: no grant, mem_en=0, burst unchanged.
  - One requester: it wins.
  - Both request, burst < MAX_BURST, and last winner still requesting: last winner wins (hold).
  - Both request, burst == MAX_BURST: the other port wins.
- burst update on grant: 1 if the winner != last, else min(burst+1, MAX_BURST). last := winner.
- mem_* are driven combinationally from the winner: mem_en=1, mem_we=winner we, addr/wdata/be passed through. When there is no winner, mem_* are 0.
- Response: rsp_v := grant, rsp_port := winner, rsp_we := winner we. Next cycle mN_rvalid=1 for rsp_port only.
- mN_rdata = mem_rdata for read responses. It is 0 for write responses and when rvalid=0.
- Writes take effect in memory at the grant edge. A read granted the cycle after a write to the same address returns the new data.
- Misaligned addresses (addr[1:0] != 0) are passed through unchanged. No checking is done.

## Timing
- Reset (reset=0, async) sets:
  - last=1, so port 0 has priority on the first contention.
  - burst=0, rsp_v=0.
  - All rvalid and rdata outputs are 0.
  - All gnt outputs and mem_en are forced to 0 while reset is low.
- Reset mid-transaction: a pending response is dropped (no rvalid after release). A write granted on the edge coinciding with reset assertion is not issued.
- Grant latency: 0 cycles, combinational from req.
- Response latency: exactly 1 cycle after grant, for reads and writes.
- Throughput: 1 access per cycle. Back-to-back grants to either port are allowed, including alternating ports.
- Worst-case wait for a continuously requesting port: MAX_BURST cycles.
- MAX_BURST=1 degenerates to strict alternation under contention.
- Simultaneous rvalid for the previous access and gnt for a new one on the same port is legal.

## Test plan
- Reset: hold reset=0 with both req=1. Required: gnt=0, mem_en=0, rvalid=0. Release reset with both requesting reads. Required: m0_gnt=1 first.
- Single port: m1 writes 0x0000000C to addr 0x8 with be=0xF, then reads addr 0x8. Required: m1_rvalid 1 cycle after each grant and m1_rdata=0x0000000C on the read. m0 signals stay 0.
- Burst limit (MAX_BURST=4): both ports request continuously. Required grant pattern is 0,0,0,0,1,1,1,1,0,… and each rvalid goes to the correct port 1 cycle later.
- Hold and yield: m0 requests continuously; m1 requests for 1 cycle at cycle 2 and is held. Required: m1_gnt no later than the 4th consecutive m0 grant + 1. burst resets to 1 when the winner changes.
- Byte enables: m0 writes 0xAABBCCDD to addr 0x0 with be=0xF, then m1 writes 0x11223344 with be=0x3, then m0 reads addr 0x0. Required: m0_rdata=0xAABB3344.
- Reset mid-operation: assert reset the cycle after an m0 read grant. Required: no m0_rvalid, and after release the arbiter behaves as from initial reset.
